// File: rtl/cache_line_adapter_pkg.sv
// Shared types for the cache line adapter.
//   lc3b_word       : 16-bit memory word / byte address
//   lc3b_8words     : 128-bit cache line, word k at bits [16k+15:16k]
//   lc3b_line_state : burst FSM states
//   LC3B_LINE_BEATS : words per line
package cache_line_adapter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_8words;

  localparam int LC3B_LINE_BEATS = 8;
  localparam int LC3B_BEAT_W     = 3;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ_BURST  = 2'd1,
    WRITE_BURST = 2'd2,
    RESP        = 2'd3
  } lc3b_line_state;

endpackage

// File: rtl/cache_line_adapter_if.sv
// Bus bundle between the cache controller (line side) and physical memory
// (word side).
//   slave  : the adapter's view (takes line requests, drives word strobes)
//   master : the environment's view (cache + memory model)
interface cache_line_adapter_if;
  import cache_line_adapter_pkg::*;

  // line side
  logic       mem_read;
  logic       mem_write;
  lc3b_word   mem_address;
  lc3b_8words mem_wdata;
  lc3b_8words mem_rdata;
  logic       mem_resp;

  // word side
  logic       pmem_read;
  logic       pmem_write;
  lc3b_word   pmem_address;
  lc3b_word   pmem_wdata;
  lc3b_word   pmem_rdata;
  logic       pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cache_line_adapter_line_buffer.sv
// 128-bit line register.
//   load_line/line_in       : full-line load (write-back capture)
//   load_word/word_idx/in   : single-word load (fill beat)
//   rd_idx/rd_word          : word-select read port
//   line_q                  : whole line
// Full-line load has priority over a word load.
module cache_line_adapter_line_buffer
  import cache_line_adapter_pkg::*;
#(
  parameter int NUM_BEATS = LC3B_LINE_BEATS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_line,
  input  lc3b_8words             line_in,
  input  logic                   load_word,
  input  logic [LC3B_BEAT_W-1:0] word_idx,
  input  lc3b_word               word_in,
  input  logic [LC3B_BEAT_W-1:0] rd_idx,
  output lc3b_8words             line_q,
  output lc3b_word               rd_word
);

  logic [NUM_BEATS-1:0][15:0] words;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words <= '0;
    end else if (load_line) begin
      words <= line_in;
    end else if (load_word) begin
      words[word_idx] <= word_in;
    end
  end

  assign line_q  = words;
  assign rd_word = words[rd_idx];

endmodule

// File: rtl/cache_line_adapter.sv
// Cache line adapter: turns one 128-bit line request from the cache into an
// 8-beat burst of 16-bit word accesses, then returns a one-cycle mem_resp.
//   clk, rst_n : clock, async active-low reset
//   bus        : line-side request/response and word-side strobes/data
// Write wins when mem_read and mem_write arrive together. Upstream address
// and data are latched on acceptance; request drops mid-burst do not abort.
module cache_line_adapter
  import cache_line_adapter_pkg::*;
#(
  parameter int NUM_BEATS   = LC3B_LINE_BEATS,
  parameter int BEAT_STRIDE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_line_adapter_if.slave  bus
);

  lc3b_line_state         state;
  logic [LC3B_BEAT_W-1:0] beat;
  logic [11:0]            base;
  logic                   mem_resp_q;
  logic                   pmem_read_q;
  logic                   pmem_write_q;
  lc3b_word               pmem_address_q;
  lc3b_word               pmem_wdata_q;

  lc3b_8words             line_q;
  lc3b_word               next_word;
  logic                   last_beat;
  logic [LC3B_BEAT_W-1:0] beat_nxt;

  function automatic lc3b_word beat_addr(input logic [11:0] b,
                                         input logic [LC3B_BEAT_W-1:0] k);
    return {b, 4'h0} + lc3b_word'(BEAT_STRIDE * int'(k));
  endfunction

  assign last_beat = (beat == LC3B_BEAT_W'(NUM_BEATS - 1));
  assign beat_nxt  = beat + 1'b1;

  // rd_idx looks one beat ahead so pmem_wdata can be registered together
  // with the address it belongs to.
  cache_line_adapter_line_buffer #(.NUM_BEATS(NUM_BEATS)) u_line_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_line (state == IDLE && bus.mem_write),
    .line_in   (bus.mem_wdata),
    .load_word (state == READ_BURST && bus.pmem_resp),
    .word_idx  (beat),
    .word_in   (bus.pmem_rdata),
    .rd_idx    (beat_nxt),
    .line_q    (line_q),
    .rd_word   (next_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      beat           <= '0;
      base           <= '0;
      mem_resp_q     <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      mem_resp_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_write) begin
            base           <= bus.mem_address[15:4];
            beat           <= '0;
            pmem_write_q   <= 1'b1;
            pmem_address_q <= beat_addr(bus.mem_address[15:4], '0);
            // buffer is loading this same edge, so take word 0 from the bus
            pmem_wdata_q   <= bus.mem_wdata[15:0];
            state          <= WRITE_BURST;
          end else if (bus.mem_read) begin
            base           <= bus.mem_address[15:4];
            beat           <= '0;
            pmem_read_q    <= 1'b1;
            pmem_address_q <= beat_addr(bus.mem_address[15:4], '0);
            state          <= READ_BURST;
          end
        end
        READ_BURST, WRITE_BURST: begin
          if (bus.pmem_resp) begin
            beat <= beat_nxt;  // wraps 7->0 on the final beat
            if (last_beat) begin
              pmem_read_q  <= 1'b0;
              pmem_write_q <= 1'b0;
              mem_resp_q   <= 1'b1;
              state        <= RESP;
            end else begin
              pmem_address_q <= beat_addr(base, beat_nxt);
              if (state == WRITE_BURST) pmem_wdata_q <= next_word;
            end
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_resp     = mem_resp_q;
  assign bus.mem_rdata    = line_q;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_cache_line_adapter.sv
module tb_cache_line_adapter;
  import cache_line_adapter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_line_adapter_if bus ();

  cache_line_adapter #(.NUM_BEATS(8), .BEAT_STRIDE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // Word memory model: answers after mem_wait idle cycles per beat, read
  // data = rd_pattern + word index within the line, logs every accepted beat.
  int        mem_wait = 0;
  int        wait_cnt = 0;
  lc3b_word  rd_pattern = 16'h0;
  lc3b_word  log_addr [64];
  lc3b_word  log_wdata[64];
  logic      log_wr   [64];
  int        log_n = 0;

  always @(negedge clk) begin
    if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
      if (wait_cnt >= mem_wait) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rd_pattern + lc3b_word'(bus.pmem_address[3:1]);
        if (log_n < 64) begin
          log_addr[log_n]  = bus.pmem_address;
          log_wdata[log_n] = bus.pmem_wdata;
          log_wr[log_n]    = bus.pmem_write;
        end
        log_n++;
        wait_cnt = 0;
      end else begin
        bus.pmem_resp = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.pmem_resp = 1'b0;
      wait_cnt = 0;
    end
  end

  // Waits (bounded) for mem_resp at a negedge; lat = cycles since t0.
  task automatic wait_resp(input int t0, output int lat, output bit got);
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mem_resp) begin
        got = 1'b1;
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.mem_address = '0; bus.mem_wdata = '0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    repeat (3) @(negedge clk);
    total++; if (bus.mem_resp !== 1'b0) begin bad++; $display("FAIL reset_mem_resp got=%b want=0", bus.mem_resp); end
    total++; if (bus.pmem_read !== 1'b0) begin bad++; $display("FAIL reset_pmem_read got=%b want=0", bus.pmem_read); end
    total++; if (bus.pmem_write !== 1'b0) begin bad++; $display("FAIL reset_pmem_write got=%b want=0", bus.pmem_write); end
    total++; if (bus.pmem_address !== 16'h0) begin bad++; $display("FAIL reset_pmem_address got=%h want=0", bus.pmem_address); end
    total++; if (bus.pmem_wdata !== 16'h0) begin bad++; $display("FAIL reset_pmem_wdata got=%h want=0", bus.pmem_wdata); end
    total++; if (bus.mem_rdata !== 128'h0) begin bad++; $display("FAIL reset_mem_rdata got=%h want=0", bus.mem_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin bad++; $display("FAIL idle_no_strobe got=%b%b want=00", bus.pmem_read, bus.pmem_write); end
  endtask

  task automatic test_read_zero_wait();
    int t0, lat; bit got; lc3b_8words exp; int errs;
    mem_wait = 0; rd_pattern = 16'hA000; log_n = 0;
    for (int k = 0; k < 8; k++) exp[16*k +: 16] = 16'hA000 + 16'(k);
    bus.mem_read = 1'b1; bus.mem_address = 16'h1234;
    t0 = cyc;
    wait_resp(t0, lat, got);
    bus.mem_read = 1'b0;
    total++; if (!got || lat != 9) begin bad++; $display("FAIL read_latency got=%0d want=9", lat); end
    total++; if (bus.mem_rdata !== exp) begin bad++; $display("FAIL read_rdata got=%h want=%h", bus.mem_rdata, exp); end
    errs = 0;
    for (int k = 0; k < 8; k++)
      if (log_addr[k] !== 16'h1230 + 16'(2*k) || log_wr[k] !== 1'b0) errs++;
    total++; if (log_n != 8 || errs != 0) begin bad++; $display("FAIL read_addr_seq beats=%0d errs=%0d want beats=8 errs=0", log_n, errs); end
    @(negedge clk);
    total++; if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin bad++; $display("FAIL read_resp_pulse got resp=%b rd=%b want 0 0", bus.mem_resp, bus.pmem_read); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_wait2();
    int t0, lat; bit got; lc3b_8words wd; int errs;
    mem_wait = 2; log_n = 0;
    for (int k = 0; k < 8; k++) wd[16*k +: 16] = 16'h0100 * 16'(k);
    bus.mem_write = 1'b1; bus.mem_address = 16'h0080; bus.mem_wdata = wd;
    t0 = cyc;
    wait_resp(t0, lat, got);
    bus.mem_write = 1'b0;
    total++; if (!got || lat != 25) begin bad++; $display("FAIL write_latency got=%0d want=25", lat); end
    errs = 0;
    for (int k = 0; k < 8; k++)
      if (log_addr[k] !== 16'h0080 + 16'(2*k) || log_wdata[k] !== 16'h0100 * 16'(k) || log_wr[k] !== 1'b1) errs++;
    total++; if (log_n != 8 || errs != 0) begin bad++; $display("FAIL write_beats beats=%0d errs=%0d want beats=8 errs=0", log_n, errs); end
    total++; if (bus.mem_rdata !== wd) begin bad++; $display("FAIL write_echo got=%h want=%h", bus.mem_rdata, wd); end
    mem_wait = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int t0, lat; bit got; int errs; lc3b_8words wd, exp;
    mem_wait = 0; rd_pattern = 16'h5500; log_n = 0;
    for (int k = 0; k < 8; k++) begin
      wd[16*k +: 16]  = 16'h7000 + 16'(k);
      exp[16*k +: 16] = 16'h5500 + 16'(k);
    end
    bus.mem_read = 1'b1; bus.mem_write = 1'b1;
    bus.mem_address = 16'h4000; bus.mem_wdata = wd;
    t0 = cyc;
    wait_resp(t0, lat, got);
    bus.mem_write = 1'b0;  // read stays held
    errs = 0;
    for (int k = 0; k < 8; k++)
      if (log_wr[k] !== 1'b1 || log_addr[k] !== 16'h4000 + 16'(2*k) || log_wdata[k] !== 16'h7000 + 16'(k)) errs++;
    total++; if (!got || log_n != 8 || errs != 0) begin bad++; $display("FAIL both_write_first beats=%0d errs=%0d want beats=8 errs=0", log_n, errs); end
    log_n = 0;
    t0 = cyc;
    wait_resp(t0, lat, got);
    bus.mem_read = 1'b0;
    // RESP, then IDLE samples the held read, then 8 beats
    total++; if (!got || lat != 10) begin bad++; $display("FAIL both_read_next latency=%0d want=10", lat); end
    errs = 0;
    for (int k = 0; k < 8; k++)
      if (log_wr[k] !== 1'b0 || log_addr[k] !== 16'h4000 + 16'(2*k)) errs++;
    total++; if (log_n != 8 || errs != 0 || bus.mem_rdata !== exp) begin bad++; $display("FAIL both_read_data beats=%0d errs=%0d rdata=%h want=%h", log_n, errs, bus.mem_rdata, exp); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop_midburst();
    int t0, lat; bit got; int errs; int pulses; lc3b_8words exp;
    mem_wait = 0; rd_pattern = 16'hB000; log_n = 0;
    for (int k = 0; k < 8; k++) exp[16*k +: 16] = 16'hB000 + 16'(k);
    bus.mem_read = 1'b1; bus.mem_address = 16'h5670;
    t0 = cyc;
    repeat (4) @(negedge clk);  // beat 3 on the bus
    total++; if (bus.pmem_address !== 16'h5676) begin bad++; $display("FAIL drop_beat3_addr got=%h want=5676", bus.pmem_address); end
    bus.mem_read = 1'b0; bus.mem_address = 16'hFFF0;
    wait_resp(t0, lat, got);
    total++; if (!got || lat != 9) begin bad++; $display("FAIL drop_latency got=%0d want=9", lat); end
    errs = 0;
    for (int k = 0; k < 8; k++) if (log_addr[k] !== 16'h5670 + 16'(2*k)) errs++;
    total++; if (log_n != 8 || errs != 0 || bus.mem_rdata !== exp) begin bad++; $display("FAIL drop_base beats=%0d errs=%0d rdata=%h want=%h", log_n, errs, bus.mem_rdata, exp); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.mem_resp) pulses++;
    end
    total++; if (pulses != 0 || log_n != 8) begin bad++; $display("FAIL drop_single_resp extra_pulses=%0d beats=%0d want 0 8", pulses, log_n); end
  endtask

  task automatic test_reset_midburst();
    int t0, lat; bit got; int errs; lc3b_8words exp;
    mem_wait = 0; rd_pattern = 16'h3300; log_n = 0;
    bus.mem_read = 1'b1; bus.mem_address = 16'h3000;
    t0 = cyc;
    repeat (6) @(negedge clk);  // beat 5 on the bus
    total++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h300A) begin bad++; $display("FAIL rst_pre_state rd=%b addr=%h want 1 300a", bus.pmem_read, bus.pmem_address); end
    #2;
    rst_n = 1'b0;
    bus.mem_read = 1'b0;
    #1;
    total++; if (bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0 || bus.pmem_address !== 16'h0 || bus.mem_rdata !== 128'h0) begin
      bad++; $display("FAIL rst_async rd=%b resp=%b addr=%h rdata=%h want all 0", bus.pmem_read, bus.mem_resp, bus.pmem_address, bus.mem_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0) begin bad++; $display("FAIL rst_idle rd=%b resp=%b want 0 0", bus.pmem_read, bus.mem_resp); end
    rd_pattern = 16'hC000; log_n = 0;
    for (int k = 0; k < 8; k++) exp[16*k +: 16] = 16'hC000 + 16'(k);
    bus.mem_read = 1'b1; bus.mem_address = 16'h2000;
    t0 = cyc;
    wait_resp(t0, lat, got);
    bus.mem_read = 1'b0;
    errs = 0;
    for (int k = 0; k < 8; k++) if (log_addr[k] !== 16'h2000 + 16'(2*k)) errs++;
    total++; if (!got || lat != 9 || log_n != 8 || errs != 0) begin bad++; $display("FAIL rst_new_read lat=%0d beats=%0d errs=%0d want 9 8 0", lat, log_n, errs); end
    total++; if (bus.mem_rdata !== exp) begin bad++; $display("FAIL rst_new_rdata got=%h want=%h", bus.mem_rdata, exp); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t0, lat; bit got; int errs; lc3b_8words wd, exp;
    mem_wait = 1; rd_pattern = 16'hD000; log_n = 0;
    for (int k = 0; k < 8; k++) begin
      wd[16*k +: 16]  = 16'hE000 | 16'(k * 3);
      exp[16*k +: 16] = 16'hD000 + 16'(k);
    end
    bus.mem_write = 1'b1; bus.mem_address = 16'h0100; bus.mem_wdata = wd;
    t0 = cyc;
    wait_resp(t0, lat, got);
    bus.mem_write = 1'b0;
    // one wait cycle per beat: 1 + 8*2
    total++; if (!got || lat != 17) begin bad++; $display("FAIL b2b_write_latency got=%0d want=17", lat); end
    @(negedge clk);  // the cycle after mem_resp
    bus.mem_read = 1'b1; bus.mem_address = 16'h0200;
    t0 = cyc;
    wait_resp(t0, lat, got);
    bus.mem_read = 1'b0;
    total++; if (!got || lat != 17) begin bad++; $display("FAIL b2b_read_latency got=%0d want=17", lat); end
    errs = 0;
    for (int k = 0; k < 8; k++) begin
      if (log_wr[k] !== 1'b1 || log_addr[k] !== 16'h0100 + 16'(2*k) || log_wdata[k] !== (16'hE000 | 16'(k * 3))) errs++;
      if (log_wr[k+8] !== 1'b0 || log_addr[k+8] !== 16'h0200 + 16'(2*k)) errs++;
    end
    total++; if (log_n != 16 || errs != 0) begin bad++; $display("FAIL b2b_beats beats=%0d errs=%0d want 16 0", log_n, errs); end
    total++; if (bus.mem_rdata !== exp) begin bad++; $display("FAIL b2b_rdata got=%h want=%h", bus.mem_rdata, exp); end
    mem_wait = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait2();
    test_simultaneous();
    test_drop_midburst();
    test_reset_midburst();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
